// File: rtl/even_ones_sched.sv
// even_ones_sched: round-robin scheduler feeding words LSB-first through a shared
// serial majority datapath and returning the collected result over valid/ready.
module even_ones_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          gnt,
    output logic                     dp_clr,
    output logic                     dp_in,
    input  logic                     dp_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic                     busy
);
    localparam int NW = $clog2(NREQ);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [NW-1:0]    last_gnt_q, last_gnt_d, sel, cand;
    logic             found;
    logic [WIDTH-1:0] word_q, word_d, res_data_q, res_data_d;
    logic [NW-1:0]    res_id_q, res_id_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             dp_clr_q, dp_clr_d;

    // Search starts just after the last granted requester.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = NW'((int'(last_gnt_q) + i) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Result bits enter at the MSB and shift down, so the first capture ends at bit 0.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        word_d     = word_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        idx_d      = idx_q;
        gnt        = '0;
        dp_in      = 1'b0;
        case (state_q)
            IDLE: if (found && !rst) begin
                gnt        = NREQ'(1) << sel;
                word_d     = req_data[sel*WIDTH +: WIDTH];
                res_id_d   = sel;
                last_gnt_d = sel;
                state_d    = CLEAR;
            end
            CLEAR: begin
                idx_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                dp_in      = word_q[idx_q];
                res_data_d = (idx_q != '0) ? {dp_out, res_data_q[WIDTH-1:1]} : res_data_q;
                idx_d      = idx_q + 1'b1;
                state_d    = (idx_q == IW'(WIDTH-1)) ? DRAIN : SHIFT;
            end
            DRAIN: begin
                res_data_d = {dp_out, res_data_q[WIDTH-1:1]};
                state_d    = DONE;
            end
            DONE: state_d = res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        dp_clr_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= NW'(NREQ-1);
            word_q     <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
            idx_q      <= '0;
            dp_clr_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            word_q     <= word_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
            idx_q      <= idx_d;
            dp_clr_q   <= dp_clr_d;
        end
    end

    assign dp_clr    = dp_clr_q;
    assign res_valid = (state_q == DONE);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_even_ones_sched.sv
// tb_even_ones_sched: directed scenario tests with a behavioral 3-bit majority datapath.
module tb_even_ones_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = {8'h0F, 8'hAA, 8'h11, 8'hFF};
    logic [3:0]  gnt;
    logic        dp_clr, dp_in, dp_out, res_valid, res_ready = 1'b0, busy;
    logic [7:0]  res_data;
    logic [1:0]  res_id;
    logic [2:0]  sr = '0;
    int          cycle = 0;
    int          checks = 0;
    int          errors = 0;

    even_ones_sched #(.NREQ(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .dp_clr(dp_clr), .dp_in(dp_in), .dp_out(dp_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Shift-register majority datapath, reset by dp_clr.
    always @(posedge clk) sr <= dp_clr ? 3'b000 : {sr[1:0], dp_in};
    assign dp_out = (sr[0] & sr[1]) | (sr[0] & sr[2]) | (sr[1] & sr[2]);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (gnt !== 4'b0) begin
                at = cycle;
                return;
            end
            cyc();
        end
        checks++; errors++;
        $display("FAIL wait_gnt: no grant within 40 cycles");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b0) return;
            cyc();
        end
        checks++; errors++;
        $display("FAIL wait_idle: still busy after 40 cycles");
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'hF; res_ready = 1'b0;
        repeat (3) cyc();
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", res_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (dp_clr !== 1'b1) begin errors++; $display("FAIL rst_dp_clr: got %b want 1", dp_clr); end
        checks++; if (dp_in !== 1'b0) begin errors++; $display("FAIL rst_dp_in: got %b want 0", dp_in); end
        rst = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rst_first_gnt: got %b want 0001", gnt); end
        cyc();
        req = 4'h0; res_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_single();
        req = 4'b0001; res_ready = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0001 || dp_clr !== 1'b0) begin errors++; $display("FAIL single_gnt: gnt=%b dp_clr=%b want 0001/0", gnt, dp_clr); end
        cyc();
        req = 4'h0;
        checks++; if (dp_clr !== 1'b1 || gnt !== 4'b0) begin errors++; $display("FAIL single_clear: dp_clr=%b gnt=%b want 1/0000", dp_clr, gnt); end
        for (int k = 2; k <= 10; k++) begin
            cyc();
            checks++; if (dp_clr !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL single_g%0d: dp_clr=%b res_valid=%b want 0/0", k, dp_clr, res_valid); end
        end
        cyc();
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", res_valid); end
        checks++; if (res_data !== 8'hFE) begin errors++; $display("FAIL single_data: got %h want fe", res_data); end
        checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", res_id); end
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_pattern();
        logic [7:0] seq;
        seq = '0;
        req = 4'b0100;
        #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL pat_gnt: got %b want 0100", gnt); end
        cyc();
        req = 4'h0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            seq[i] = dp_in;
        end
        checks++; if (seq !== 8'hAA) begin errors++; $display("FAIL pat_dp_in: got %h want aa", seq); end
        cyc();
        cyc();
        checks++; if (res_valid !== 1'b1 || res_data !== 8'hA8 || res_id !== 2'd2) begin
            errors++; $display("FAIL pat_result: valid=%b data=%h id=%0d want 1/a8/2", res_valid, res_data, res_id);
        end
        cyc();
    endtask

    task automatic test_round_robin();
        int exp_rr[6] = '{0, 1, 2, 3, 0, 2};
        int at, prev;
        prev = 0;
        rst = 1'b1;
        cyc();
        rst = 1'b0; req = 4'hF; res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) req = 4'b0101;
            wait_gnt(at);
            checks++; if (gnt !== 4'(1 << exp_rr[k])) begin errors++; $display("FAIL rr_gnt%0d: got %b want %b", k, gnt, 4'(1 << exp_rr[k])); end
            if (k > 0) begin
                checks++; if (at - prev !== 12) begin errors++; $display("FAIL rr_space%0d: got %0d want 12", k, at - prev); end
            end
            prev = at;
            cyc();
        end
        req = 4'h0;
        wait_idle();
    endtask

    task automatic test_backpressure();
        req = 4'b0011; res_ready = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL bp_gnt: got %b want 0001", gnt); end
        cyc();
        req = 4'b0010;
        repeat (10) cyc();
        for (int i = 0; i < 5; i++) begin
            checks++; if (res_valid !== 1'b1 || res_data !== 8'hFE || res_id !== 2'd0 || gnt !== 4'b0) begin
                errors++; $display("FAIL bp_hold%0d: valid=%b data=%h id=%0d gnt=%b want 1/fe/0/0000", i, res_valid, res_data, res_id, gnt);
            end
            cyc();
        end
        res_ready = 1'b1;
        #1;
        checks++; if (res_valid !== 1'b1 || gnt !== 4'b0) begin errors++; $display("FAIL bp_hs: valid=%b gnt=%b want 1/0000", res_valid, gnt); end
        cyc();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL bp_next_gnt: got %b want 0010", gnt); end
        cyc();
        req = 4'h0;
        wait_idle();
    endtask

    task automatic test_reset_mid_shift();
        req = 4'b0001; res_ready = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_gnt: got %b want 0001", gnt); end
        cyc();
        req = 4'h0;
        repeat (5) cyc();
        checks++; if (busy !== 1'b1 || dp_in !== 1'b1) begin errors++; $display("FAIL mid_shift: busy=%b dp_in=%b want 1/1", busy, dp_in); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || dp_clr !== 1'b1 || dp_in !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL mid_after_rst: busy=%b dp_clr=%b dp_in=%b valid=%b want 0/1/0/0", busy, dp_clr, dp_in, res_valid);
        end
        for (int i = 0; i < 12; i++) begin
            cyc();
            checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_quiet%0d: valid=%b busy=%b want 0/0", i, res_valid, busy); end
        end
        req = 4'b0011;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_regrant: got %b want 0001", gnt); end
        cyc();
        req = 4'h0;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_pattern();
        test_round_robin();
        test_backpressure();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
